mf_peak_trigger: RTL
====================

Name: mf_peak_trigger

Overview:
- Per-channel trigger stage placed directly downstream of the matched filter.
- Each clock it takes one SSR beat of NSAMPS signed filter outputs and computes the saturated magnitude of each sample.
- It finds the beat maximum and compares it to a programmable threshold.
- On a crossing it emits a trigger pulse, captures the peak over a short window, then enforces a holdoff.

Parameters:
NBITS, 18, signed width of each input sample (matched filter output width)
NSAMPS, 8, samples per beat; sample 0 is earliest in the beat
PEAK_BEATS, 4, beats in the peak-capture window, including the trigger beat (>=1)
HOLDOFF_BITS, 8, width of the holdoff count

Ports:
aclk  in  1  clock; reset is asynchronous and active-high
arst  in  1  asynchronous active-high reset
data_i  in  NBITS*NSAMPS  signed samples, sample i at [NBITS*i +: NBITS]
enable_i  in  1  arms triggering when high
thresh_i  in  NBITS-1  unsigned magnitude threshold
thresh_wr_i  in  1  single-cycle write strobe for thresh_i
holdoff_i  in  HOLDOFF_BITS  holdoff length in beats
trig_o  out  1  one-cycle trigger pulse
peak_valid_o  out  1  one-cycle strobe; peak outputs valid while high
peak_o  out  NBITS-1  peak magnitude within the capture window
peak_idx_o  out  $clog2(NSAMPS)  sample index of the peak
peak_beat_o  out  $clog2(PEAK_BEATS)+1  beat offset of the peak; 0 = trigger beat
trig_count_o  out  16  saturating trigger counter

Behaviour:
- Reset (async, any time, including mid-capture):
  - All outputs and pipeline registers clear to 0; FSM goes to IDLE.
  - Active and shadow thresholds reset to all-ones, so no trigger can fire.
- Stage 1, magnitude: registered |x|.
  - -2^(NBITS-1) saturates to 2^(NBITS-1)-1.
  - Result is NBITS-1 bits unsigned.
- Stages 2-4, max tree: registered pairwise-max tree (8→4→2→1) carrying the sample index.
  - Ties go to the lower index (earliest sample).
  - Beat max M and index are registered at stage 4.
  - Beat presented at cycle n has M valid at cycle n+4.
- Exceed condition: combinational `exceed = (M > active_thresh)`, strictly greater.
- FSM states: IDLE, CAPTURE, HOLDOFF. Transitions are registered.
  - IDLE: if enable_i && exceed && stage-4 valid:
    - trig_o=1 the next cycle (n+5 for beat n).
    - Latch peak = M, idx, beat=0; latch holdoff_i; increment trig_count_o (saturates at 65535).
    - If PEAK_BEATS==1, go to the output step; otherwise go to CAPTURE with beat counter = 1.
  - CAPTURE: each cycle, if M > peak (strict), update peak, idx, and beat = counter.
    - Counter increments each cycle.
    - When the last window beat (counter == PEAK_BEATS-1) is absorbed, peak_valid_o=1 the next cycle with final values.
    - Then go to HOLDOFF, or to IDLE if the latched holdoff is 0.
    - enable_i is ignored in CAPTURE; the window always completes.
  - HOLDOFF: count down the latched holdoff, one per cycle; go to IDLE when it reaches 0.
    - Exceeds are ignored in this state.
    - IDLE may retrigger on the first cycle after HOLDOFF ends.
- Stage-4 valid: a 4-bit valid shift register cleared by reset; no trigger until the pipeline has filled after reset.
- Peak outputs: peak_o, peak_idx_o, and peak_beat_o hold their values until the next peak_valid_o.
- trig_o and peak_valid_o may both be high in the same cycle only when PEAK_BEATS==1.
- Threshold update:
  - thresh_wr_i loads the shadow register.
  - The active threshold takes the shadow value on any cycle the FSM is in IDLE, effective the next cycle.
  - Writes made during CAPTURE/HOLDOFF apply on return to IDLE.
  - If a write and a trigger coincide in IDLE, the old threshold judges that beat.
- enable_i low in IDLE: no trigger; the pipeline keeps running.

Test Plan:
1. Reset, no thresh write, full-scale input (all samples 0x1FFFF) → trig_o never asserts; trig_count_o=0.
2. thresh=1000, holdoff=0; single beat at cycle 10 with sample 5 = -1500, all else 0 → trig_o at cycle 15; peak_valid_o at 18 with peak_o=1500, peak_idx_o=5, peak_beat_o=0; trig_count_o=1.
3. thresh=1000; beats with max 1200 (idx 2), 3000 (idx 7, beat 1), 3000 (idx 0, beat 2) → peak_o=3000, peak_idx_o=7, peak_beat_o=1 (strict update, earliest wins).
4. thresh=100, holdoff=10, continuous input of 500 → triggers spaced PEAK_BEATS+10=14 cycles apart; count increments per trigger.
5. Sample = -2^17 → magnitude 131071; beat with two equal maxima at idx 3 and 6 → peak_idx_o=3.
6. thresh write 50 during HOLDOFF, then input 80 after return to IDLE → trigger fires; assert arst mid-CAPTURE → outputs 0 immediately; no peak_valid_o follows.

Source files
------------

// File: rtl/mf_peak_trigger.sv
// mf_peak_trigger: per-channel trigger stage after the matched filter.
// Saturated magnitude, registered beat-max tree, then a trigger / peak-capture / holdoff FSM.
module mf_peak_trigger #(
    parameter int NBITS        = 18,
    parameter int NSAMPS       = 8,
    parameter int PEAK_BEATS   = 4,
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                        aclk,
    input  logic                        arst,
    input  logic [NBITS*NSAMPS-1:0]     data_i,
    input  logic                        enable_i,
    input  logic [NBITS-2:0]            thresh_i,
    input  logic                        thresh_wr_i,
    input  logic [HOLDOFF_BITS-1:0]     holdoff_i,
    output logic                        trig_o,
    output logic                        peak_valid_o,
    output logic [NBITS-2:0]            peak_o,
    output logic [$clog2(NSAMPS)-1:0]   peak_idx_o,
    output logic [$clog2(PEAK_BEATS):0] peak_beat_o,
    output logic [15:0]                 trig_count_o
);
    localparam int MW    = NBITS - 1;
    localparam int IW    = $clog2(NSAMPS);
    localparam int BW    = $clog2(PEAK_BEATS) + 1;
    localparam int DEPTH = IW + 1;
    localparam int HALF  = NSAMPS / 2;

    localparam logic [BW-1:0]           LAST_BEAT = BW'(PEAK_BEATS - 1);
    localparam logic [BW-1:0]           BEAT_ONE  = BW'(1);
    localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE  = HOLDOFF_BITS'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // The most negative code has no positive twin, so it clips to full scale.
    function automatic logic [MW-1:0] sat_mag(input logic [NBITS-1:0] x);
        if (x[NBITS-1] == 1'b0) begin
            sat_mag = x[MW-1:0];
        end else if (x[MW-1:0] == {MW{1'b0}}) begin
            sat_mag = {MW{1'b1}};
        end else begin
            sat_mag = ~x[MW-1:0] + {{(MW-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [MW-1:0]    tree_mag [DEPTH][NSAMPS];
    logic [IW-1:0]    tree_idx [DEPTH][NSAMPS];
    logic [DEPTH-1:0] valid_sr;

    logic [MW-1:0]    beat_max;
    logic [IW-1:0]    beat_idx;
    logic             beat_valid;
    logic             exceed;

    logic [MW-1:0]    shadow_thresh;
    logic [MW-1:0]    active_thresh;

    state_t                  state, state_nxt;
    logic [BW-1:0]           cnt, cnt_nxt;
    logic [HOLDOFF_BITS-1:0] hold_cnt, hold_nxt;
    logic [MW-1:0]           cap_peak, cap_peak_nxt;
    logic [IW-1:0]           cap_idx, cap_idx_nxt;
    logic [BW-1:0]           cap_beat, cap_beat_nxt;
    logic [MW-1:0]           win_peak;
    logic [IW-1:0]           win_idx;
    logic [BW-1:0]           win_beat;
    logic                    trig_nxt, pv_nxt;
    logic [MW-1:0]           peak_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [BW-1:0]           beat_nxt;
    logic [15:0]             count_nxt;

    // Magnitude stage followed by the pairwise max levels; on ties the lower index survives.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int l = 0; l < DEPTH; l++) begin
                for (int j = 0; j < NSAMPS; j++) begin
                    tree_mag[l][j] <= {MW{1'b0}};
                    tree_idx[l][j] <= {IW{1'b0}};
                end
            end
            valid_sr <= {DEPTH{1'b0}};
        end else begin
            for (int j = 0; j < NSAMPS; j++) begin
                tree_mag[0][j] <= sat_mag(data_i[NBITS*j +: NBITS]);
                tree_idx[0][j] <= IW'(j);
            end
            for (int l = 1; l < DEPTH; l++) begin
                for (int j = 0; j < HALF; j++) begin
                    if (tree_mag[l-1][2*j+1] > tree_mag[l-1][2*j]) begin
                        tree_mag[l][j] <= tree_mag[l-1][2*j+1];
                        tree_idx[l][j] <= tree_idx[l-1][2*j+1];
                    end else begin
                        tree_mag[l][j] <= tree_mag[l-1][2*j];
                        tree_idx[l][j] <= tree_idx[l-1][2*j];
                    end
                end
                for (int j = HALF; j < NSAMPS; j++) begin
                    tree_mag[l][j] <= {MW{1'b0}};
                    tree_idx[l][j] <= {IW{1'b0}};
                end
            end
            valid_sr <= {valid_sr[DEPTH-2:0], 1'b1};
        end
    end

    assign beat_max   = tree_mag[DEPTH-1][0];
    assign beat_idx   = tree_idx[DEPTH-1][0];
    assign beat_valid = valid_sr[DEPTH-1];
    assign exceed     = beat_valid && (beat_max > active_thresh);

    // Writes land in the shadow; the active copy only follows it while idle.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            shadow_thresh <= {MW{1'b1}};
            active_thresh <= {MW{1'b1}};
        end else begin
            if (thresh_wr_i) begin
                shadow_thresh <= thresh_i;
            end
            if (state == IDLE) begin
                active_thresh <= shadow_thresh;
            end
        end
    end

    // Next-state and next-output logic for the trigger FSM.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hold_nxt     = hold_cnt;
        cap_peak_nxt = cap_peak;
        cap_idx_nxt  = cap_idx;
        cap_beat_nxt = cap_beat;
        trig_nxt     = 1'b0;
        pv_nxt       = 1'b0;
        peak_nxt     = peak_o;
        idx_nxt      = peak_idx_o;
        beat_nxt     = peak_beat_o;
        count_nxt    = trig_count_o;

        if (beat_max > cap_peak) begin
            win_peak = beat_max;
            win_idx  = beat_idx;
            win_beat = cnt;
        end else begin
            win_peak = cap_peak;
            win_idx  = cap_idx;
            win_beat = cap_beat;
        end

        case (state)
            IDLE: begin
                if (enable_i && exceed) begin
                    trig_nxt     = 1'b1;
                    cap_peak_nxt = beat_max;
                    cap_idx_nxt  = beat_idx;
                    cap_beat_nxt = {BW{1'b0}};
                    hold_nxt     = holdoff_i;
                    if (trig_count_o != 16'hFFFF) begin
                        count_nxt = trig_count_o + 16'd1;
                    end else begin
                        count_nxt = trig_count_o;
                    end
                    if (PEAK_BEATS == 1) begin
                        pv_nxt    = 1'b1;
                        peak_nxt  = beat_max;
                        idx_nxt   = beat_idx;
                        beat_nxt  = {BW{1'b0}};
                        state_nxt = (holdoff_i == {HOLDOFF_BITS{1'b0}}) ? IDLE : HOLDOFF;
                    end else begin
                        cnt_nxt   = BEAT_ONE;
                        state_nxt = CAPTURE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                cap_peak_nxt = win_peak;
                cap_idx_nxt  = win_idx;
                cap_beat_nxt = win_beat;
                if (cnt == LAST_BEAT) begin
                    pv_nxt    = 1'b1;
                    peak_nxt  = win_peak;
                    idx_nxt   = win_idx;
                    beat_nxt  = win_beat;
                    state_nxt = (hold_cnt == {HOLDOFF_BITS{1'b0}}) ? IDLE : HOLDOFF;
                end else begin
                    cnt_nxt = cnt + BEAT_ONE;
                end
            end
            HOLDOFF: begin
                if (hold_cnt <= HOLD_ONE) begin
                    hold_nxt  = {HOLDOFF_BITS{1'b0}};
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold_cnt - HOLD_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, capture working registers and the registered outputs.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state        <= IDLE;
            cnt          <= {BW{1'b0}};
            hold_cnt     <= {HOLDOFF_BITS{1'b0}};
            cap_peak     <= {MW{1'b0}};
            cap_idx      <= {IW{1'b0}};
            cap_beat     <= {BW{1'b0}};
            trig_o       <= 1'b0;
            peak_valid_o <= 1'b0;
            peak_o       <= {MW{1'b0}};
            peak_idx_o   <= {IW{1'b0}};
            peak_beat_o  <= {BW{1'b0}};
            trig_count_o <= 16'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hold_cnt     <= hold_nxt;
            cap_peak     <= cap_peak_nxt;
            cap_idx      <= cap_idx_nxt;
            cap_beat     <= cap_beat_nxt;
            trig_o       <= trig_nxt;
            peak_valid_o <= pv_nxt;
            peak_o       <= peak_nxt;
            peak_idx_o   <= idx_nxt;
            peak_beat_o  <= beat_nxt;
            trig_count_o <= count_nxt;
        end
    end

endmodule
